// File: rtl/vga_pkg.sv
// Shared timing constants, colour-bar palette and axis direction type for the bounce-box pixel stage.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 521;
  localparam int HS_START = 655;
  localparam int HS_END   = 750;
  localparam int VS_START = 489;
  localparam int VS_END   = 490;

  // First h_cnt of bars 1..6; bar 0 starts at column 0.
  localparam logic [9:0] BAR1_START = 10'd91;
  localparam logic [9:0] BAR2_START = 10'd182;
  localparam logic [9:0] BAR3_START = 10'd273;
  localparam logic [9:0] BAR4_START = 10'd364;
  localparam logic [9:0] BAR5_START = 10'd455;
  localparam logic [9:0] BAR6_START = 10'd546;

  localparam logic [11:0] BAR0_COLOR = 12'hF00;
  localparam logic [11:0] BAR1_COLOR = 12'hF80;
  localparam logic [11:0] BAR2_COLOR = 12'hFF0;
  localparam logic [11:0] BAR3_COLOR = 12'h080;
  localparam logic [11:0] BAR4_COLOR = 12'h00F;
  localparam logic [11:0] BAR5_COLOR = 12'h508;
  localparam logic [11:0] BAR6_COLOR = 12'h808;

  typedef enum logic {DIR_INC, DIR_DEC} dir_e;

  function automatic logic [2:0] bar_index(input logic [9:0] h);
    if (h < BAR1_START)      return 3'd0;
    else if (h < BAR2_START) return 3'd1;
    else if (h < BAR3_START) return 3'd2;
    else if (h < BAR4_START) return 3'd3;
    else if (h < BAR5_START) return 3'd4;
    else if (h < BAR6_START) return 3'd5;
    else                     return 3'd6;
  endfunction

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR0_COLOR;
      3'd1:    return BAR1_COLOR;
      3'd2:    return BAR2_COLOR;
      3'd3:    return BAR3_COLOR;
      3'd4:    return BAR4_COLOR;
      3'd5:    return BAR5_COLOR;
      default: return BAR6_COLOR;
    endcase
  endfunction

endpackage

// File: rtl/vga_bounce_box_axis.sv
// One axis of the bouncing box: position register plus INC/DEC direction FSM, stepping once per frame tick.
module box_axis
  import vga_pkg::*;
#(
  parameter int MAX  = 608,
  parameter int STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pause,
  output logic [9:0] pos,
  output dir_e       dir
);

  localparam logic [10:0] MAX_W  = 11'(MAX);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [9:0]  pos_q, pos_d;
  dir_e        dir_q, dir_d;
  logic [10:0] pos_ext;
  logic [10:0] pos_sum;

  assign pos_ext = {1'b0, pos_q};
  assign pos_sum = pos_ext + STEP_W;

  // Clamp and turn on the same tick so the box never overshoots an edge.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick && !pause) begin
      case (dir_q)
        DIR_INC: begin
          if (pos_sum >= MAX_W) begin
            pos_d = MAX_W[9:0];
            dir_d = DIR_DEC;
          end else begin
            pos_d = pos_sum[9:0];
          end
        end
        default: begin
          if (pos_ext <= STEP_W) begin
            pos_d = 10'd0;
            dir_d = DIR_INC;
          end else begin
            pos_d = pos_q - STEP_W[9:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= 10'd0;
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/vga_bounce_box.sv
// Colour-bar background with a bouncing box overlay; 2-cycle pipeline with delay-matched syncs.
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int          BOX_W     = 32,
  parameter int          BOX_H     = 32,
  parameter int          STEP      = 2,
  parameter logic [11:0] BOX_COLOR = 12'hFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       hsync,
  output logic       vsync
);

  logic       tick;
  logic [9:0] x_pos, y_pos;
  dir_e       x_dir, y_dir;

  // End of the last active line: moving here keeps the whole next frame consistent.
  assign tick = (h_cnt == 10'(H_TOTAL - 1)) && (v_cnt == 10'(V_ACTIVE - 1));

  box_axis #(.MAX(H_ACTIVE - BOX_W), .STEP(STEP)) u_x (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .pos(x_pos), .dir(x_dir)
  );

  box_axis #(.MAX(V_ACTIVE - BOX_H), .STEP(STEP)) u_y (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .pos(y_pos), .dir(y_dir)
  );

  logic        active_q, active_d;
  logic        in_box_q, in_box_d;
  logic [2:0]  bar_q, bar_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d;
  logic [10:0] h_ext, v_ext, x_ext, y_ext;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};
  assign x_ext = {1'b0, x_pos};
  assign y_ext = {1'b0, y_pos};

  always_comb begin
    active_d = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    in_box_d = (h_ext >= x_ext) && (h_ext < x_ext + 11'(BOX_W)) &&
               (v_ext >= y_ext) && (v_ext < y_ext + 11'(BOX_H));
    bar_d    = bar_index(h_cnt);
    hs1_d    = hsync_in;
    vs1_d    = vsync_in;
  end

  always_comb begin
    rgb_d = 12'h000;
    if (active_q) rgb_d = in_box_q ? BOX_COLOR : bar_color(bar_q);
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  // Both stages reset so syncs read inactive until real data reaches the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      in_box_q <= 1'b0;
      bar_q    <= 3'd0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      rgb_q    <= 12'h000;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      in_box_q <= in_box_d;
      bar_q    <= bar_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      rgb_q    <= rgb_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
    end
  end

  assign r     = rgb_q[11:8];
  assign g     = rgb_q[7:4];
  assign b     = rgb_q[3:0];
  assign hsync = hs2_q;
  assign vsync = vs2_q;

endmodule

// File: doc/vga_bounce_box.md
# vga_bounce_box

Pixel-generation stage that sits directly upstream of the VGA output pins and consumes the raw counters and syncs from the 640x480 timing stage. It paints the 7-column colour-bar background and overlays a solid square that bounces off the visible edges, moving once per frame. Colour and syncs are pipelined and delay-matched, so the output drives the 4-bit R/G/B and sync pins directly.

## Interface
Parameters:
- BOX_W, 32, box width in pixels (2..320).
- BOX_H, 32, box height in pixels (2..240).
- STEP, 2, pixels moved per frame per axis (1..16).
- BOX_COLOR, 12'hFFF, box colour {R,G,B}.

Ports:
- clk  in  1  pixel clock (25 MHz domain). One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- h_cnt  in  10  horizontal counter from the timing stage, 0..799.
- v_cnt  in  10  vertical counter from the timing stage, 0..520.
- hsync_in  in  1  active-low hsync from the timing stage, aligned with h_cnt.
- vsync_in  in  1  active-low vsync from the timing stage, aligned with v_cnt.
- pause  in  1  level input. While high, the box position and direction are frozen.
- r, g, b  out  4 each  pixel colour.
- hsync, vsync  out  1 each  syncs delayed to match the colour outputs.

## Operation
- Active region: h_cnt < 640 and v_cnt < 480. Outside it, the colour is 12'h000.
- Background by h_cnt:
  - 0-90: f00
  - 91-181: f80
  - 182-272: ff0
  - 273-363: 080
  - 364-454: 00f
  - 455-545: 508
  - 546-639: 808
- Box hit condition: x ≤ h_cnt < x+BOX_W and y ≤ v_cnt < y+BOX_H. When it holds in the active region, the output is BOX_COLOR, which has priority over the background.
- Position registers: x and y are 10-bit unsigned. X_MAX = 640−BOX_W and Y_MAX = 480−BOX_H.
- Frame tick: asserted for one cycle when h_cnt==799 and v_cnt==479, i.e. at the end of the last active line. Position updates only on this tick and only if pause is low, so there is no tearing.
- Per-axis direction FSM with states INC and DEC:
  - In INC: if pos+STEP ≥ MAX, then pos←MAX and go to DEC. Otherwise pos←pos+STEP.
  - In DEC: if pos ≤ STEP, then pos←0 and go to INC. Otherwise pos←pos−STEP.
  - The clamp and the turn happen on the same tick.
- x and y update on the same tick and independently. A corner hit flips both directions.
- Reset state: x=0, y=0, both axes INC.

## Timing
- Fixed latency of 2 cycles. The colour, hsync and vsync at cycle t+2 correspond to h_cnt, v_cnt, hsync_in and vsync_in sampled at cycle t.
- Stage 1 registers: active, in_box, background colour index, and the syncs.
- Stage 2 registers: the final colour mux and the syncs.
- Outputs during reset and on the first cycle after it:
  - r, g, b = 0
  - hsync = vsync = 1 (inactive)
- Pipeline contents are discarded by reset. Valid output resumes 2 cycles after rst deasserts.
- A new position from a frame tick is visible starting at pixel (0,0) of the next frame.
- pause is sampled only on the tick cycle.
- Reset mid-frame returns position and direction to the reset state immediately, regardless of the frame tick.

## Structure
- Package vga_pkg holds:
  - Timing constants: H_ACTIVE=640, H_TOTAL=800, V_ACTIVE=480, V_TOTAL=521, HS_START=655, HS_END=750, VS_START=489, VS_END=490.
  - The seven bar colour constants and bar boundaries.
  - The direction enum {DIR_INC, DIR_DEC}.
- Sub-module box_axis holds one axis's position register and direction FSM.
  - Parameters: MAX, STEP.
  - Ports: clk, rst, tick, pause, pos[9:0], dir.
  - Instantiated twice, once for x and once for y.

## Test plan
- Reset: hold rst for 5 cycles with sync inputs low. Required: r=g=b=0 and hsync=vsync=1 throughout, then x=0, y=0, INC/INC.
- Latency/background: drive h_cnt=100, v_cnt=300 (box at 0,0) at cycle t. Required: {r,g,b}=f80 at t+2. Drive h_cnt=640 at t. Required: 000 at t+2. A hsync_in edge appears on hsync exactly 2 cycles later.
- Box overlay: after reset, frame 0, pixel (10,10). Required: FFF. Pixel (32,10) shows the bar colour f00.
- Right-edge bounce with defaults: after 304 ticks, x=608 and dir=DEC. Tick 305 gives x=606. After 224 ticks, y=448 and the y axis has turned.
- Pause: hold pause high across 3 frame ticks. Required: x and y unchanged. Release pause: the next tick gives x+2.
- Mid-frame reset: with x=200 and the counters at line 240, assert rst for 1 cycle. Required: x=y=0, the outputs go to the reset values, and the next frame draws the box at (0,0).
